// File: rtl/xbar_alloc_n_pkg.sv
// Shared defaults, flat-vector slice macro and index helpers
// for the N-port switch allocator / crossbar.
`ifndef XBAR_ALLOC_N_PKG_SV
`define XBAR_ALLOC_N_PKG_SV

`define XB_SL(v, i, w) v[(i)*(w) +: (w)]

package xbar_alloc_n_pkg;

    localparam int XB_NPORT = 5;
    localparam int XB_DATAW = 64;
    localparam int XB_VCHW  = 2;
    localparam int XB_PW    = $clog2(XB_NPORT);
    localparam int XB_MAXN  = 16;

    // OR-reduction of set-bit positions; exact for one-hot input
    function automatic logic [3:0] oh2idx(
        input logic [XB_MAXN-1:0] oh
    );
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < XB_MAXN; i++) begin
            if (oh[i]) begin
                r = r | 4'(i);
            end
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/xbar_alloc_n_rr_arb.sv
// Round-robin arbiter: grants the first request at or after ptr_i,
// scanning cyclically. Output is one-hot or zero.
module rr_arb_n
    import xbar_alloc_n_pkg::*;
#(
    parameter int N  = XB_NPORT,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_alloc_n.sv
// N-port wormhole switch allocator and data crossbar with packet
// locking, per-output round-robin and all-or-nothing multicast.
module xbar_alloc_n
    import xbar_alloc_n_pkg::*;
#(
    parameter int NPORT = XB_NPORT,
    parameter int DATAW = XB_DATAW,
    parameter int VCHW  = XB_VCHW,
    parameter int PW    = $clog2(NPORT)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT*VCHW-1:0]  ivch,
    input  logic [NPORT-1:0]       ilast,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT*NPORT-1:0] req_mask,
    output logic [NPORT*NPORT-1:0] grt,
    output logic [NPORT*DATAW-1:0] odata,
    output logic [NPORT*VCHW-1:0]  ovch,
    output logic [NPORT-1:0]       ovalid
);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return PW'((int'(p) + 1) % NPORT);
    endfunction

    logic [NPORT-1:0]       mask [NPORT];
    logic [NPORT-1:0]       is_mc;
    logic [NPORT-1:0]       is_uc;

    logic [NPORT-1:0]       lock_vld_q;
    logic [NPORT-1:0]       lock_vld_d;
    logic [PW-1:0]          lock_own_q [NPORT];
    logic [PW-1:0]          lock_own_d [NPORT];
    logic [PW-1:0]          rr_ptr_q [NPORT];
    logic [PW-1:0]          rr_ptr_d [NPORT];
    logic [PW-1:0]          mc_ptr_q;
    logic [PW-1:0]          mc_ptr_d;

    logic [NPORT*DATAW-1:0] odata_q;
    logic [NPORT*VCHW-1:0]  ovch_q;
    logic [NPORT-1:0]       ovalid_d;
    logic [NPORT-1:0]       ovalid_q;

    logic [PW-1:0]          cand;
    logic                   m_vld;
    logic [PW-1:0]          m_idx;
    logic                   m_blk;
    logic                   m_go;
    logic [NPORT-1:0]       m_out;
    logic [NPORT-1:0]       uc_win;
    logic [NPORT-1:0]       uc_req [NPORT];
    logic [NPORT-1:0]       uc_gnt [NPORT];
    logic [NPORT-1:0]       col [NPORT];
    logic [PW-1:0]          win [NPORT];

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            mask[i]  = `XB_SL(req_mask, i, NPORT);
            is_mc[i] = req[i] && ($countones(mask[i]) >= 2);
            is_uc[i] = req[i] && ($countones(mask[i]) == 1);
        end
    end

    // Multicast candidate: first multicast requester from mc_ptr
    always_comb begin
        m_vld = 1'b0;
        m_idx = '0;
        cand  = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = PW'((int'(mc_ptr_q) + k) % NPORT);
            if (!m_vld && is_mc[cand]) begin
                m_vld = 1'b1;
                m_idx = cand;
            end
        end
    end

    always_comb begin
        m_blk = 1'b0;
        for (int o = 0; o < NPORT; o++) begin
            if (m_vld && mask[m_idx][o] && lock_vld_q[o] &&
                lock_own_q[o] != m_idx) begin
                m_blk = 1'b1;
            end
        end
    end

    assign m_go = m_vld && !m_blk;

    // m_out: unlocked outputs claimed by M, granted or reserved
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            m_out[o] = m_vld && mask[m_idx][o] && !lock_vld_q[o];
            for (int i = 0; i < NPORT; i++) begin
                uc_req[o][i] = is_uc[i] && mask[i][o];
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arb_n #(
            .N  (NPORT),
            .PW (PW)
        ) u_arb (
            .req_i (uc_req[o]),
            .ptr_i (rr_ptr_q[o]),
            .gnt_o (uc_gnt[o])
        );
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            col[o]    = '0;
            uc_win[o] = 1'b0;
            if (lock_vld_q[o]) begin
                if (req[lock_own_q[o]] && mask[lock_own_q[o]][o]) begin
                    col[o][lock_own_q[o]] = 1'b1;
                end
            end else if (m_out[o]) begin
                if (m_go) begin
                    col[o][m_idx] = 1'b1;
                end
            end else begin
                col[o]    = uc_gnt[o];
                uc_win[o] = |uc_gnt[o];
            end
        end
    end

    always_comb begin
        grt = '0;
        for (int i = 0; i < NPORT; i++) begin
            for (int o = 0; o < NPORT; o++) begin
                grt[i*NPORT+o] = col[o][i];
            end
        end
    end

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        rr_ptr_d   = rr_ptr_q;
        mc_ptr_d   = mc_ptr_q;
        for (int o = 0; o < NPORT; o++) begin
            win[o]      = PW'(oh2idx(XB_MAXN'(col[o])));
            ovalid_d[o] = |col[o];
            if (ovalid_d[o]) begin
                lock_vld_d[o] = !ilast[win[o]];
                lock_own_d[o] = win[o];
                if (uc_win[o]) begin
                    rr_ptr_d[o] = nxt(win[o]);
                end
            end
        end
        if (m_go && ilast[m_idx]) begin
            mc_ptr_d = nxt(m_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            lock_vld_q <= '0;
            mc_ptr_q   <= '0;
            odata_q    <= '0;
            ovch_q     <= '0;
            ovalid_q   <= '0;
            for (int o = 0; o < NPORT; o++) begin
                lock_own_q[o] <= '0;
                rr_ptr_q[o]   <= '0;
            end
        end else begin
            lock_vld_q <= lock_vld_d;
            mc_ptr_q   <= mc_ptr_d;
            ovalid_q   <= ovalid_d;
            for (int o = 0; o < NPORT; o++) begin
                lock_own_q[o] <= lock_own_d[o];
                rr_ptr_q[o]   <= rr_ptr_d[o];
                if (ovalid_d[o]) begin
                    `XB_SL(odata_q, o, DATAW) <= `XB_SL(idata, win[o], DATAW);
                    `XB_SL(ovch_q, o, VCHW)   <= `XB_SL(ivch, win[o], VCHW);
                end
            end
        end
    end

    assign odata  = odata_q;
    assign ovch   = ovch_q;
    assign ovalid = ovalid_q;

endmodule

// File: tb/tb_xbar_alloc_n.sv
// Self-checking bench for xbar_alloc_n: directed scenarios plus
// random traffic against a packet-level reference model.
module tb_xbar_alloc_n;

    localparam int NP = 5;
    localparam int DW = 32;
    localparam int VW = 2;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic [NP*DW-1:0]  idata = '0;
    logic [NP*VW-1:0]  ivch = '0;
    logic [NP-1:0]     ilast = '0;
    logic [NP-1:0]     req = '0;
    logic [NP*NP-1:0]  req_mask = '0;
    logic [NP*NP-1:0]  grt;
    logic [NP*DW-1:0]  odata;
    logic [NP*VW-1:0]  ovch;
    logic [NP-1:0]     ovalid;

    xbar_alloc_n #(
        .NPORT (NP),
        .DATAW (DW),
        .VCHW  (VW)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata    (idata),
        .ivch     (ivch),
        .ilast    (ilast),
        .req      (req),
        .req_mask (req_mask),
        .grt      (grt),
        .odata    (odata),
        .ovch     (ovch),
        .ovalid   (ovalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0] msk;
        logic          lst;
        logic [DW-1:0] dat;
        logic [VW-1:0] vc;
        logic          bub;
    } flit_t;

    flit_t q [NP][$];
    flit_t cur [NP];
    bit    prq [NP];

    // reference model state: own = -1 means output free
    int             own [NP];
    int             rr [NP];
    int             mc;
    logic [DW-1:0]  od [NP];
    logic [VW-1:0]  ovc [NP];
    logic           ov [NP];
    int             win [NP];
    bit             ucw [NP];
    int             mi;
    bit             mok;
    logic [NP*NP-1:0] eg;

    int             ev_c [$];
    int             ev_i [$];
    logic [NP-1:0]  ev_m [$];
    int             wl [$];
    int             cyc_n = 0;
    int             errs = 0;
    int             checks = 0;
    int             exp_rr [4] = '{0, 2, 4, 0};

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < NP; o++) begin
            own[o] = -1;
            rr[o]  = 0;
            od[o]  = '0;
            ovc[o] = '0;
            ov[o]  = 1'b0;
        end
        mc = 0;
    endtask

    task automatic add(int i, logic [NP-1:0] m, logic l, logic b);
        flit_t f;
        f.msk = m;
        f.lst = l;
        f.dat = $urandom;
        f.vc  = VW'($urandom);
        f.bub = b;
        q[i].push_back(f);
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() > 0 && !q[i][0].bub) begin
                prq[i] = 1'b1;
                cur[i] = q[i][0];
            end else begin
                prq[i]     = 1'b0;
                cur[i].msk = NP'($urandom);
                cur[i].lst = 1'($urandom);
                cur[i].dat = $urandom;
                cur[i].vc  = VW'($urandom);
                cur[i].bub = 1'b0;
            end
            req[i]             = prq[i];
            ilast[i]           = cur[i].lst;
            req_mask[i*NP+:NP] = cur[i].msk;
            idata[i*DW+:DW]    = cur[i].dat;
            ivch[i*VW+:VW]     = cur[i].vc;
        end
    endtask

    task automatic model_alloc();
        bit taken [NP];
        int c;
        for (int o = 0; o < NP; o++) begin
            win[o]   = -1;
            ucw[o]   = 1'b0;
            taken[o] = 1'b0;
        end
        for (int o = 0; o < NP; o++) begin
            if (own[o] >= 0 && prq[own[o]] && cur[own[o]].msk[o]) begin
                win[o] = own[o];
            end
        end
        mi  = -1;
        mok = 1'b0;
        for (int k = 0; k < NP; k++) begin
            c = (mc + k) % NP;
            if (mi < 0 && prq[c] && $countones(cur[c].msk) >= 2) mi = c;
        end
        if (mi >= 0) begin
            mok = 1'b1;
            for (int o = 0; o < NP; o++) begin
                if (cur[mi].msk[o] && own[o] >= 0 && own[o] != mi) mok = 1'b0;
            end
            for (int o = 0; o < NP; o++) begin
                if (cur[mi].msk[o] && own[o] < 0) begin
                    taken[o] = 1'b1;
                    if (mok) win[o] = mi;
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (own[o] < 0 && !taken[o]) begin
                for (int k = 0; k < NP; k++) begin
                    c = (rr[o] + k) % NP;
                    if (win[o] < 0 && prq[c] && $countones(cur[c].msk) == 1 &&
                        cur[c].msk[o]) begin
                        win[o] = c;
                        ucw[o] = 1'b1;
                    end
                end
            end
        end
        eg = '0;
        for (int o = 0; o < NP; o++) begin
            if (win[o] >= 0) eg[win[o]*NP+o] = 1'b1;
        end
    endtask

    task automatic model_commit();
        int w;
        for (int o = 0; o < NP; o++) begin
            w = win[o];
            if (w >= 0) begin
                own[o] = cur[w].lst ? -1 : w;
                od[o]  = cur[w].dat;
                ovc[o] = cur[w].vc;
                ov[o]  = 1'b1;
                if (ucw[o]) rr[o] = (w + 1) % NP;
            end else begin
                ov[o] = 1'b0;
            end
        end
        if (mi >= 0 && mok && cur[mi].lst) mc = (mi + 1) % NP;
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() > 0 && (q[i][0].bub || (prq[i] &&
                (eg[i*NP+:NP] != '0 || cur[i].msk == '0)))) begin
                void'(q[i].pop_front());
            end
        end
    endtask

    task automatic cyc();
        logic [NP-1:0]    g;
        logic             pg;
        logic [NP*DW-1:0] xd;
        logic [NP*VW-1:0] xv;
        logic [NP-1:0]    xo;
        drive();
        #1;
        model_alloc();
        chk("grt", 256'(grt), 256'(eg));
        pg = 1'b1;
        for (int i = 0; i < NP; i++) begin
            g = grt[i*NP+:NP];
            if (g != '0) begin
                ev_c.push_back(cyc_n);
                ev_i.push_back(i);
                ev_m.push_back(g);
                if (!prq[i] || g != cur[i].msk) pg = 1'b0;
            end
        end
        chk("no_partial", 256'(pg), 256'(1));
        @(posedge clk);
        model_commit();
        #1;
        for (int o = 0; o < NP; o++) begin
            xd[o*DW+:DW] = od[o];
            xv[o*VW+:VW] = ovc[o];
            xo[o]        = ov[o];
        end
        chk("ovalid", 256'(ovalid), 256'(xo));
        chk("odata", 256'(odata), 256'(xd));
        chk("ovch", 256'(ovch), 256'(xv));
        @(negedge clk);
        cyc_n++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run(string tag, int maxc);
        int n;
        n = 0;
        while (!all_empty() && n < maxc) begin
            cyc();
            n++;
        end
        chk_i({tag, "_drain"}, int'(all_empty()), 1);
    endtask

    task automatic clr_log();
        ev_c.delete();
        ev_i.delete();
        ev_m.delete();
    endtask

    function automatic int nth_cyc(int i, int n);
        int k;
        k = 0;
        foreach (ev_c[e]) begin
            if (ev_i[e] == i) begin
                if (k == n) return ev_c[e];
                k++;
            end
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] nth_msk(int i, int n);
        int k;
        k = 0;
        foreach (ev_c[e]) begin
            if (ev_i[e] == i) begin
                if (k == n) return ev_m[e];
                k++;
            end
        end
        return '0;
    endfunction

    function automatic int cnt(int i);
        int k;
        k = 0;
        foreach (ev_i[e]) if (ev_i[e] == i) k++;
        return k;
    endfunction

    task automatic gen_pkt(int i);
        int            k;
        int            len;
        logic [NP-1:0] m;
        k = $urandom_range(0, 9);
        if (k == 0) begin
            add(i, '0, 1'($urandom_range(0, 1)), 1'b0);
            return;
        end
        m = '0;
        if (k <= 3) begin
            while ($countones(m) < 2) m = NP'($urandom);
        end else begin
            m = NP'(1) << $urandom_range(0, NP - 1);
        end
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 7) == 0) add(i, '0, 1'b0, 1'b1);
            add(i, m, j == len - 1, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        chk("rst_ovalid", 256'(ovalid), 256'(0));
        chk("rst_odata", 256'(odata), 256'(0));
        chk("rst_ovch", 256'(ovch), 256'(0));
        rst_ = 1'b1;

        // reset in the middle of a packet locking out1 to in2
        add(2, 5'b00010, 1'b0, 1'b0);
        add(2, 5'b00010, 1'b0, 1'b0);
        add(2, 5'b00010, 1'b0, 1'b0);
        add(2, 5'b00010, 1'b1, 1'b0);
        cyc();
        cyc();
        rst_ = 1'b0;
        for (int i = 0; i < NP; i++) q[i].delete();
        drive();
        #1;
        model_reset();
        chk("rstmid_ovalid", 256'(ovalid), 256'(0));
        chk("rstmid_odata", 256'(odata), 256'(0));
        @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        clr_log();
        add(0, 5'b00010, 1'b1, 1'b0);
        cyc();
        chk_i("rstmid_in0_first", nth_cyc(0, 0), cyc_n - 1);
        chk("rstmid_in0_mask", 256'(nth_msk(0, 0)), 256'(5'b00010));

        // round-robin on out3
        clr_log();
        for (int r = 0; r < 2; r++) begin
            add(0, 5'b01000, 1'b1, 1'b0);
            add(2, 5'b01000, 1'b1, 1'b0);
            add(4, 5'b01000, 1'b1, 1'b0);
        end
        run("rr", 40);
        wl.delete();
        foreach (ev_c[e]) if (ev_m[e][3]) wl.push_back(ev_i[e]);
        for (int k = 0; k < 4; k++) begin
            chk_i($sformatf("rr_order%0d", k),
                  (k < wl.size()) ? wl[k] : -1, exp_rr[k]);
        end

        // wormhole lock with a bubble
        clr_log();
        add(1, 5'b00001, 1'b0, 1'b0);
        add(1, 5'b00001, 1'b0, 1'b0);
        add(1, '0, 1'b0, 1'b1);
        add(1, 5'b00001, 1'b0, 1'b0);
        add(1, 5'b00001, 1'b1, 1'b0);
        add(3, 5'b00001, 1'b1, 1'b0);
        run("wh", 40);
        chk_i("wh_in1_flits", cnt(1), 4);
        chk_i("wh_in1_span", nth_cyc(1, 3) - nth_cyc(1, 0), 4);
        chk_i("wh_in3_after_tail", nth_cyc(3, 0), nth_cyc(1, 3) + 1);

        // single-flit multicast, all outputs free
        clr_log();
        add(2, 5'b01011, 1'b1, 1'b0);
        run("mc", 10);
        chk("mc_grant", 256'(nth_msk(2, 0)), 256'(5'b01011));
        chk_i("mc_cnt", cnt(2), 1);

        // multicast blocked by out1 lock; out2 reserved
        clr_log();
        add(0, 5'b00010, 1'b0, 1'b0);
        add(0, 5'b00010, 1'b0, 1'b0);
        add(0, 5'b00010, 1'b0, 1'b0);
        add(0, 5'b00010, 1'b1, 1'b0);
        add(4, '0, 1'b0, 1'b1);
        add(4, 5'b00110, 1'b1, 1'b0);
        add(3, '0, 1'b0, 1'b1);
        add(3, 5'b00100, 1'b1, 1'b0);
        run("mcb", 40);
        chk_i("mcb_in4_after_tail", nth_cyc(4, 0), nth_cyc(0, 3) + 1);
        chk("mcb_in4_mask", 256'(nth_msk(4, 0)), 256'(5'b00110));
        chk_i("mcb_in3_after_in4", nth_cyc(3, 0), nth_cyc(4, 0) + 1);

        // two competing multicasts from mc_ptr = 0
        clr_log();
        add(1, 5'b10001, 1'b1, 1'b0);
        add(3, 5'b10001, 1'b1, 1'b0);
        run("mc2", 20);
        chk_i("mc2_order", nth_cyc(3, 0) - nth_cyc(1, 0), 1);
        chk("mc2_in1_mask", 256'(nth_msk(1, 0)), 256'(5'b10001));
        chk("mc2_in3_mask", 256'(nth_msk(3, 0)), 256'(5'b10001));

        // random traffic
        clr_log();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 2) == 0) gen_pkt(i);
            end
            cyc();
        end
        run("rand", 400);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
